// File: rtl/ones_stream_if.sv
// Word-in / serial-out bundle for ones_stream_tx.
// Master side offers words and applies hold; slave side serializes.
interface ones_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             hold;
  logic             data_out;
  logic             bit_valid;
  logic [1:0]       ones_mod4;
  logic             four_ones_exp;
  logic             word_done;

  modport master (
    output tx_data,
    output tx_valid,
    output hold,
    input  tx_ready,
    input  data_out,
    input  bit_valid,
    input  ones_mod4,
    input  four_ones_exp,
    input  word_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  hold,
    output tx_ready,
    output data_out,
    output bit_valid,
    output ones_mod4,
    output four_ones_exp,
    output word_done
  );
endinterface

// File: rtl/ones_stream_tx.sv
// MSB-first word serializer with hold stalls, inter-word gap
// and a running mod-4 count of transmitted ones.
module ones_stream_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic          clk,
  input logic          reset,
  ones_stream_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    left_q, left_d;
  logic [3:0]       gap_q, gap_d;
  logic             dout_q, dout_d;
  logic             bv_q, bv_d;
  logic             done_q, done_d;
  logic [1:0]       ones_q, ones_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      left_q  <= '0;
      gap_q   <= '0;
      dout_q  <= 1'b0;
      bv_q    <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      left_q  <= left_d;
      gap_q   <= gap_d;
      dout_q  <= dout_d;
      bv_q    <= bv_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
    end
  end

  // left_q counts payload bits still to present after the current one
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    left_d  = left_q;
    gap_d   = gap_q;
    dout_d  = 1'b0;
    bv_d    = 1'b0;
    done_d  = 1'b0;
    ones_d  = ones_q + {1'b0, bv_q & dout_q};
    unique case (state_q)
      IDLE: begin
        if (bus.tx_valid) begin
          sh_d    = {bus.tx_data[WIDTH-2:0], 1'b0};
          dout_d  = bus.tx_data[WIDTH-1];
          bv_d    = 1'b1;
          left_d  = CW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!bus.hold) begin
          if (left_q == '0) begin
            state_d = GAP;
            done_d  = 1'b1;
            gap_d   = 4'(GAP_CYCLES - 1);
          end else begin
            dout_d = sh_q[WIDTH-1];
            bv_d   = 1'b1;
            sh_d   = sh_q << 1;
            left_d = left_q - 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_ready      = (state_q == IDLE) && !reset;
  assign bus.data_out      = dout_q;
  assign bus.bit_valid     = bv_q;
  assign bus.word_done     = done_q;
  assign bus.ones_mod4     = ones_q;
  assign bus.four_ones_exp = (ones_q == 2'd3);

endmodule

// File: doc/ones_stream_tx.md
ONES_STREAM_TX -- requirements
Module: ones_stream_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width in bits (range 2..32).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles inserted after each word (range 1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; clock clk.
REQ-005 tx_data  input  WIDTH  parallel word to serialize; sampled only on an accepted handshake.
REQ-006 tx_valid  input  1  upstream asserts a word is offered.
REQ-007 tx_ready  output  1  high iff block is in IDLE and reset is low.
REQ-008 hold  input  1  downstream backpressure; pauses bit emission.
REQ-009 data_out  output  1  serial bit, MSB first; registered.
REQ-010 bit_valid  output  1  high in cycles where data_out carries a payload bit; registered.
REQ-011 ones_mod4  output  2  count, mod 4, of ones emitted with bit_valid=1; registered.
REQ-012 four_ones_exp  output  1  high iff ones_mod4 == 3; mirrors a downstream four-ones detector fed by data_out.
REQ-013 word_done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-014 SHALL implement states IDLE, SHIFT, GAP.
REQ-015 Handshake accepted at an edge where tx_valid=1 and tx_ready=1; tx_data captured into shift register at that edge.
REQ-016 At the accepting edge SHALL load data_out<=tx_data[WIDTH-1], bit_valid<=1, state<=SHIFT (first bit visible the cycle after acceptance, latency 1).
REQ-017 In SHIFT, at each edge with hold=0, SHALL present the next lower bit; with hold=1, SHALL drive data_out=0, bit_valid=0 and retain the pending bit index.
REQ-018 After the bit at index 0 has been presented with bit_valid=1, the next edge with hold=0 SHALL enter GAP with data_out=0, bit_valid=0, word_done=1 for exactly that one cycle.
REQ-019 A word SHALL occupy exactly WIDTH bit_valid cycles regardless of hold stalls.
REQ-020 GAP SHALL last GAP_CYCLES cycles (hold ignored), then return to IDLE.
REQ-021 data_out SHALL be 0 whenever bit_valid=0 (IDLE, GAP, hold stalls).
REQ-022 At every edge where bit_valid=1 and data_out=1, ones_mod4 SHALL increment, wrapping 3->0; otherwise unchanged. Count persists across words.
REQ-023 tx_valid and tx_data changes while not in IDLE SHALL be ignored; no queuing.
REQ-024 Hold asserted during IDLE or GAP SHALL have no effect.
REQ-025 Cycle-level equivalence: ones_mod4 SHALL equal the state, and four_ones_exp the output, of a mod-4 ones detector reset with this block and sampling data_out every clock.

Reset
REQ-026 reset=1 at an edge SHALL force state=IDLE, data_out=0, bit_valid=0, ones_mod4=0, four_ones_exp=0, word_done=0, shift register and bit index cleared.
REQ-027 tx_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.
REQ-028 Reset mid-word SHALL abort the word immediately; no word_done, no partial bits after reset.
REQ-029 Reset SHALL take priority over handshake, hold and all state transitions in the same cycle.

Verification (WIDTH=8, GAP_CYCLES=2)
REQ-030 Reset, send 8'hF0, hold=0 -> data_out 1,1,1,1,0,0,0,0 on cycles 1..8 after accept; ones_mod4 1,2,3,0 after bits 1..4; four_ones_exp high exactly one cycle; word_done in cycle 9; tx_ready high in cycle 11.
REQ-031 Send 8'hA5, hold=1 for 3 cycles after bit 3 -> 3 gap cycles with bit_valid=0, data_out=0; bit sequence still 1,0,1,0,0,1,0,1; word_done 3 cycles later than unstalled case; ones_mod4 ends at 0.
REQ-032 Back-to-back 8'hFF then 8'h01 with tx_valid held high -> second accepted first cycle tx_ready returns; exactly 16 bit_valid cycles; final ones_mod4=1.
REQ-033 Reset asserted after bit 4 of 8'hFF -> next cycle bit_valid=0, ones_mod4=0, no word_done; fresh 8'h0F afterwards transmits all 8 bits correctly.
REQ-034 Send 8'h00 while toggling tx_data/tx_valid during SHIFT -> 8 zero bits, ones_mod4 unchanged, single word_done, no extra acceptance.
REQ-035 Random words with random hold, scoreboarded against a reference mod-4 ones detector on data_out -> ones_mod4 and four_ones_exp match every cycle.
